// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: access sizes, FSM states
// and lane widths, plus the alignment rule used when a request is accepted.
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LD_WAIT  = 2'b01,
    ST_RMW_WAIT = 2'b10,
    ST_RMW_WR   = 2'b11
  } state_e;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    res = (size == SZ_RSVD) ? SZ_WORD : size;
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic res;
    case (size)
      SZ_HALF: res = lo[0];
      SZ_WORD: res = (lo != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Little-endian lane handling: extracts and extends a loaded byte/half, and merges
// a sub-word store into the old memory word.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        lane_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  // Lane selection from the read word
  always_comb begin
    case (lane_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Sign or zero extension of the selected lane
  always_comb begin
    case (size_i)
      SZ_BYTE: load_o = {{(DATA_W-BYTE_W){byte_s[BYTE_W-1] & ~unsigned_i}}, byte_s};
      SZ_HALF: load_o = {{(DATA_W-HALF_W){half_s[HALF_W-1] & ~unsigned_i}}, half_s};
      default: load_o = rdata_i;
    endcase
  end

  // Store merge of the low byte/half of wdata into the old word
  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) begin
          merged_o[31:16] = wdata_i[15:0];
        end else begin
          merged_o[15:0] = wdata_i[15:0];
        end
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller in front of a word-addressed memory with 1-cycle registered
// reads: loads with extension, single-cycle word stores, read-modify-write sub-word stores.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               req_valid_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  input  logic [NB_ADDR+1:0] addr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  output logic               stall_o,
  output logic [NB_DATA-1:0] load_data_o,
  output logic               load_valid_o,
  output logic               misaligned_o,
  output logic               mem_enable_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic [NB_DATA-1:0] mem_wdata_o,
  input  logic [NB_DATA-1:0] mem_rdata_i
);

  state_e             state_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [NB_DATA-1:0] wdata_q;
  logic [NB_DATA-1:0] buf_q;
  logic [NB_DATA-1:0] load_data_q;
  logic               load_valid_q;

  logic [1:0]         size_s;
  logic [NB_ADDR-1:0] req_addr_s;
  logic               misalign_s;
  logic               req_s;
  logic               load_s;
  logic               store_s;
  logic               wstore_s;
  logic               rmw_s;
  logic [NB_DATA-1:0] lane_load_s;
  logic [NB_DATA-1:0] lane_merged_s;

  assign size_s     = norm_size(size_i);
  assign req_addr_s = addr_i[NB_ADDR+1:2];
  assign misalign_s = is_misaligned(size_s, addr_i[1:0]);
  assign req_s      = enable_i & req_valid_i & (state_q == ST_IDLE);
  // A simultaneous read and write is a load; the write is dropped.
  assign load_s     = req_s & mem_read_i & ~misalign_s;
  assign store_s    = req_s & ~mem_read_i & mem_write_i & ~misalign_s;
  assign wstore_s   = store_s & (size_s == SZ_WORD);
  assign rmw_s      = store_s & (size_s != SZ_WORD);

  byte_lane_unit u_lane (
    .rdata_i    (mem_rdata_i),
    .wdata_i    (wdata_q),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (lane_load_s),
    .merged_o   (lane_merged_s)
  );

  // Access FSM, capture registers and registered load result
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= {NB_ADDR{1'b0}};
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= {NB_DATA{1'b0}};
      buf_q        <= {NB_DATA{1'b0}};
      load_data_q  <= {NB_DATA{1'b0}};
      load_valid_q <= 1'b0;
    end else if (enable_i) begin
      load_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_s) begin
            state_q <= ST_LD_WAIT;
            addr_q  <= req_addr_s;
            lane_q  <= addr_i[1:0];
            size_q  <= size_s;
            uns_q   <= unsigned_i;
          end else if (rmw_s) begin
            state_q <= ST_RMW_WAIT;
            addr_q  <= req_addr_s;
            lane_q  <= addr_i[1:0];
            size_q  <= size_s;
            wdata_q <= wdata_i;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LD_WAIT: begin
          load_data_q  <= lane_load_s;
          load_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        ST_RMW_WAIT: begin
          buf_q   <= lane_merged_s;
          state_q <= ST_RMW_WR;
        end
        ST_RMW_WR: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port drive; enable stays low in wait states so the memory output holds
  always_comb begin
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    mem_enable_o = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {NB_ADDR{1'b0}};
    mem_wdata_o  = {NB_DATA{1'b0}};
    if (reset_i) begin
      case (state_q)
        ST_IDLE: begin
          misaligned_o = req_s & (mem_read_i | mem_write_i) & misalign_s;
          stall_o      = load_s | rmw_s;
          mem_enable_o = load_s | store_s;
          mem_read_o   = load_s | rmw_s;
          mem_write_o  = wstore_s;
          mem_addr_o   = (load_s | store_s) ? req_addr_s : {NB_ADDR{1'b0}};
          mem_wdata_o  = wstore_s ? wdata_i : {NB_DATA{1'b0}};
        end
        ST_LD_WAIT, ST_RMW_WAIT: begin
          stall_o    = 1'b1;
          mem_addr_o = addr_q;
        end
        ST_RMW_WR: begin
          mem_enable_o = enable_i;
          mem_write_o  = enable_i;
          mem_addr_o   = addr_q;
          mem_wdata_o  = buf_q;
        end
        default: stall_o = 1'b0;
      endcase
    end else begin
      stall_o = 1'b0;
    end
  end

  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;

endmodule
